// File: rtl/proc_control_unit.sv
// Control FSM for the simple 16-bit add/sub processor: fetches a 9-bit instruction and sequences T0..T3.
// Optional macro CTRL_MVNZ_EN enables opcode 100 as move-if-G-not-zero.
module proc_control_unit #(
  parameter int unsigned OPC_W = 3,
  parameter int unsigned NREG  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [15:0]     din,
  input  logic            g_zero,
  output logic            ir_in,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            din_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic            add_sub,
  output logic            done
);

  localparam int unsigned IDX_W = $clog2(NREG);
  localparam int unsigned IR_W  = OPC_W + 2 * IDX_W;

  localparam logic [OPC_W-1:0] OP_MV  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_MVI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
`ifdef CTRL_MVNZ_EN
  localparam logic [OPC_W-1:0] OP_MVNZ = OPC_W'(4);
`endif

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IR_W-1:0]     ir;
  logic [OPC_W-1:0]    opc;
  logic [IDX_W-1:0]    rx;
  logic [IDX_W-1:0]    ry;
  logic [NREG-1:0]     sel_x;
  logic [NREG-1:0]     sel_y;
  logic                unused_inputs;

  // Instruction fields: III XXX YYY
  assign opc   = ir[IR_W-1 -: OPC_W];
  assign rx    = ir[2*IDX_W-1 -: IDX_W];
  assign ry    = ir[IDX_W-1:0];
  assign sel_x = NREG'(1) << rx;
  assign sel_y = NREG'(1) << ry;

  // Upper din bits carry immediates for the datapath only; g_zero is dead without mvnz.
  assign unused_inputs = ^{din[15:IR_W], g_zero};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_in) ir <= din[IR_W-1:0];
    end
  end

  // Strobe decode; reset forces every output low so an aborted instruction writes nothing.
  always_comb begin
    state_nxt = state;
    ir_in     = 1'b0;
    r_in      = '0;
    r_out     = '0;
    din_out   = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    g_out     = 1'b0;
    add_sub   = 1'b0;
    done      = 1'b0;
    if (!reset) begin
      case (state)
        T0: begin
          ir_in = run;
          if (run) state_nxt = T1;
        end
        T1: begin
          state_nxt = T0;
          case (opc)
            OP_MV: begin
              r_out = sel_y;
              r_in  = sel_x;
              done  = 1'b1;
            end
            OP_MVI: begin
              din_out = 1'b1;
              r_in    = sel_x;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              r_out     = sel_x;
              a_in      = 1'b1;
              state_nxt = T2;
            end
`ifdef CTRL_MVNZ_EN
            OP_MVNZ: begin
              done = 1'b1;
              if (!g_zero) begin
                r_out = sel_y;
                r_in  = sel_x;
              end
            end
`endif
            default: done = 1'b1;
          endcase
        end
        T2: begin
          r_out     = sel_y;
          g_in      = 1'b1;
          add_sub   = ir[IR_W-OPC_W];
          state_nxt = T3;
        end
        T3: begin
          g_out     = 1'b1;
          r_in      = sel_x;
          done      = 1'b1;
          state_nxt = T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: drives a behavioural datapath from the DUT strobes
// and compares per-cycle strobes and architectural register contents against an instruction-level model.
module tb_proc_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        g_zero;
  logic        ir_in, din_out, a_in, g_in, g_out, add_sub, done;
  logic [7:0]  r_in, r_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  proc_control_unit #(.OPC_W(3), .NREG(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .g_zero  (g_zero),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .din_out (din_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .add_sub (add_sub),
    .done    (done)
  );

  // Datapath driven only by the DUT's strobes
  logic [15:0] regs [8];
  logic [15:0] a_reg, g_reg, bus;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 8; i++) if (r_out[i]) bus = regs[i];
    if (din_out) bus = din;
    if (g_out)   bus = g_reg;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 8; i++) if (r_in[i]) regs[i] <= bus;
    if (a_in) a_reg <= bus;
    if (g_in) g_reg <= add_sub ? a_reg - bus : a_reg + bus;
  end

  // Architectural reference register file
  logic [15:0] ref_regs [8];

  logic [22:0] act;
  assign act = {ir_in, r_in, r_out, din_out, a_in, g_in, g_out, add_sub, done};

  localparam logic [7:0] Z8 = 8'h00;

  function automatic logic [22:0] pk(input logic iri, input logic [7:0] ri, input logic [7:0] ro,
                                     input logic dio, input logic ai, input logic gi,
                                     input logic go, input logic as, input logic dn);
    return {iri, ri, ro, dio, ai, gi, go, as, dn};
  endfunction

  function automatic logic [7:0] oh(input int i);
    return 8'(1) << i;
  endfunction

  // Issue one instruction with run held in T0; check each cycle's strobes, then the register file.
  task automatic run_instr(input string name, input logic [8:0] ir, input logic [15:0] imm,
                           input logic gz);
    logic [22:0] q[$];
    int op, x, y;
    bit bad;
    op = int'(ir[8:6]);
    x  = int'(ir[5:3]);
    y  = int'(ir[2:0]);
    q.push_back(pk(1'b1, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    case (op)
      0: begin
        q.push_back(pk(1'b0, oh(x), oh(y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref_regs[x] = ref_regs[y];
      end
      1: begin
        q.push_back(pk(1'b0, oh(x), Z8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        ref_regs[x] = imm;
      end
      2, 3: begin
        q.push_back(pk(1'b0, Z8, oh(x), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(pk(1'b0, Z8, oh(y), 1'b0, 1'b0, 1'b1, 1'b0, (op == 3), 1'b0));
        q.push_back(pk(1'b0, oh(x), Z8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        ref_regs[x] = (op == 3) ? ref_regs[x] - ref_regs[y] : ref_regs[x] + ref_regs[y];
      end
`ifdef CTRL_MVNZ_EN
      4: begin
        if (!gz) begin
          q.push_back(pk(1'b0, oh(x), oh(y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
          ref_regs[x] = ref_regs[y];
        end else begin
          q.push_back(pk(1'b0, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
      end
`endif
      default: q.push_back(pk(1'b0, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endcase
    for (int k = 0; k < q.size(); k++) begin
      run    = (k == 0) ? 1'b1 : 1'($urandom);
      din    = (k == 0) ? {7'($urandom), ir} : ((k == 1) ? imm : 16'($urandom));
      g_zero = (k == 1) ? gz : 1'($urandom);
      @(negedge clock);
      n_total++;
      if (act !== q[k])
        $display("FAIL %s step%0d ir=%o got %h exp %h", name, k, ir, act, q[k]);
      else
        n_pass++;
      @(posedge clock);
      #1;
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) if (regs[i] !== ref_regs[i]) bad = 1'b1;
    n_total++;
    if (bad)
      $display("FAIL %s regfile ir=%o got R%0d=%h exp %h", name, ir, x, regs[x], ref_regs[x]);
    else
      n_pass++;
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      run    = 1'b0;
      din    = 16'($urandom);
      g_zero = 1'($urandom);
      @(negedge clock);
      n_total++;
      if (act !== 23'h0) $display("FAIL %s idle got %h exp %h", name, act, 23'h0);
      else n_pass++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    run    = 1'b1;
    din    = 16'o010;
    g_zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_total++;
      if (act !== 23'h0) $display("FAIL reset cyc%0d got %h exp %h", k, act, 23'h0);
      else n_pass++;
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_mvi();
    run_instr("mvi_r2", 9'o123, 16'h1234, 1'b0);
    for (int i = 0; i < 8; i++)
      run_instr("mvi_all", {3'd1, 3'(i), 3'($urandom)}, 16'($urandom), 1'b0);
  endtask

  task automatic test_add_sub();
    run_instr("ld_r1", 9'o110, 16'd5, 1'b0);
    run_instr("ld_r5", 9'o150, 16'd3, 1'b0);
    run_instr("add", 9'o215, 16'($urandom), 1'b0);
    n_total++;
    if (regs[1] !== 16'd8) $display("FAIL add_value got %0d exp %0d", regs[1], 8);
    else n_pass++;
    run_instr("ld_r1", 9'o110, 16'd5, 1'b0);
    run_instr("sub", 9'o315, 16'($urandom), 1'b0);
    n_total++;
    if (regs[1] !== 16'd2) $display("FAIL sub_value got %0d exp %0d", regs[1], 2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_add", 9'o243, 16'h0, 1'b0);
    run_instr("b2b_mv", 9'o036, 16'h0, 1'b0);
    run_instr("b2b_dbl", 9'o222, 16'h0, 1'b0);
    run_instr("b2b_zero", 9'o366, 16'h0, 1'b0);
    run_instr("b2b_nop", 9'o712, 16'h0, 1'b0);
  endtask

  task automatic test_idle();
    idle_cycles("idle", 4);
    run_instr("after_idle", 9'o054, 16'h0, 1'b0);
  endtask

  task automatic test_mvnz();
    run_instr("ld_r2", 9'o120, 16'hbeef, 1'b0);
    run_instr("mvnz_g0", 9'o412, 16'h0, 1'b0);
    run_instr("ld_r1", 9'o110, 16'h0007, 1'b0);
    run_instr("mvnz_g1", 9'o412, 16'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_instr("ld_r1", 9'o110, 16'd5, 1'b0);
    run_instr("ld_r5", 9'o150, 16'd3, 1'b0);
    run = 1'b1;
    din = {7'h0, 9'o215};
    @(negedge clock);
    n_total++;
    if (act !== pk(1'b1, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0))
      $display("FAIL abort_fetch got %h", act);
    else n_pass++;
    @(posedge clock);
    #1;
    run = 1'b0;
    @(negedge clock);
    n_total++;
    if (act !== pk(1'b0, Z8, oh(1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0))
      $display("FAIL abort_t1 got %h", act);
    else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b1;
    run   = 1'b1;
    @(negedge clock);
    n_total++;
    if (act !== 23'h0) $display("FAIL abort_t2 got %h exp %h", act, 23'h0);
    else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_total++;
    if (regs[1] !== 16'd5) $display("FAIL abort_dest got %0d exp %0d", regs[1], 5);
    else n_pass++;
    run_instr("after_abort", 9'o073, 16'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(3) == 0) idle_cycles("rand_idle", int'($urandom_range(3, 1)));
      run_instr("rand", 9'($urandom), 16'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_add_sub();
    test_back_to_back();
    test_idle();
    test_mvnz();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
